jtag_tap: RTL and testbench
===========================

# jtag_tap

IEEE 1149.1-style test access port for the scanchain. It consumes the `tck`/`tms`/`tdi` signals produced by the scanchain controller and oversamples them in the `clk` domain. It runs the standard 16-state TAP FSM and returns `tdo` plus an echoed `rtck` to the controller. An instruction register selects among IDCODE, a user data register (parallel in/out to design pins) and BYPASS.

## Interface
- `IR_WIDTH`, 4: instruction register width (min 2).
- `DR_WIDTH`, 8: user data register width.
- `IDCODE`, 32'h10A5_E001: device ID value; bit 0 must be 1.
- `clk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: reset, synchronous, active-high; clock clk.
- `tck` in 1: test clock from the controller, asynchronous to `clk`.
- `tms` in 1: test mode select.
- `tdi` in 1: test data in.
- `user_in` in DR_WIDTH: parallel capture value for USER DR.
- `tdo` out 1: test data out.
- `rtck` out 1: return clock, the synchronised and delayed `tck`.
- `user_out` out DR_WIDTH: parallel update value of USER DR.
- `tap_state` out 4: current TAP state encoding.
- `update_pulse` out 1: one-`clk` pulse on Update-DR while USER is selected.

## Operation
- `tck`, `tms` and `tdi` each pass through a 2-flop synchroniser.
- `tck_q` holds the previous synchronised `tck`.
  - rise = `tck_s & ~tck_q`
  - fall = `~tck_s & tck_q`
- On rise:
  - The state advances on `tms_s`.
  - In Shift-IR or Shift-DR, the selected register shifts right, with `tdi_s` entering the MSB.
  - Capture and Update actions execute while in Capture/Update states.
- On fall: `tdo` is set to the LSB of the selected shift register in Shift-IR/Shift-DR; otherwise `tdo` is 0.
- State encoding (the standard 1149.1 encoding):
  - TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauDR 3, Ex2DR 0, UpdDR 5
  - SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauIR B, Ex2IR 8, UpdIR D
- Transitions follow the standard 1149.1 TAP diagram. Five rises with `tms`=1 reach TLR from any state.
- Capture-IR loads `{IR_WIDTH-2 zeros, 2'b01}` into the IR shift register.
- Update-IR copies the IR shift register into `ir`.
- Instruction decode:
  - 1 = IDCODE (32-bit)
  - 2 = USER (DR_WIDTH)
  - all ones = BYPASS (1-bit)
  - any other code = BYPASS
- Capture-DR loads:
  - IDCODE: `IDCODE`
  - USER: `user_in`
  - BYPASS: 0
- Update-DR with USER selected: `user_out` takes the shift register value and `update_pulse` is high for one `clk`.
- Entering TLR sets `ir` to IDCODE. `user_out` is not cleared by TLR.
- While the TAP is stalled (no `tck` edges), all registers hold.

## Timing
- Reset values:
  - state TLR, `ir` IDCODE, shift registers 0
  - `tdo` 0, `user_out` 0, `update_pulse` 0
  - `rtck` equals `tck_q`
- During reset, the synchronisers keep sampling and `tck_q` tracks `tck_s`. This prevents a spurious edge at reset release.
- Reset mid-shift: the shift is abandoned and `user_out` is cleared.
- Latencies:
  - `tck` pin edge to state/shift update: 3 `clk`
  - `tck` falling edge to `tdo`: 3 `clk`
  - `rtck` = `tck_q`, i.e. `tck` delayed 3 `clk`
- `tck` high and low times must each be ≥4 `clk`. Narrower pulses give undefined behaviour.
- The controller may use `rtck` to pace `tck`.
- `tms` and `tdi` must be stable ≥1 `clk` before the `tck` rising edge at the pins.
- Rise and fall are mutually exclusive by construction.
- `update_pulse` is asserted in the same `clk` that `user_out` changes.

## Configuration
- `TAP_IDCODE_EN` defined:
  - The IDCODE instruction and the 32-bit IDCODE register exist.
  - Reset and TLR load `ir` with 1.
- `TAP_IDCODE_EN` undefined:
  - No IDCODE register; code 1 decodes as BYPASS.
  - Reset and TLR load `ir` with all ones.
  - After reset, a DR shift therefore yields a 1-bit bypass (captured 0).

## Test plan
- Reset, then 5 `tck` with `tms`=1 -> `tap_state`=F, `tdo`=0, `user_out`=0.
- IDCODE read with macro on: TLR→CapDR→ShDR, 32 `tck` -> `tdo` bits LSB-first equal 32'h10A5_E001.
- IR scan shifting 4'h2 -> bits shifted out during ShIR are 1,0,0,0 (captured 0001 LSB first); after UpdIR, `ir`=2.
- USER DR with `user_in`=8'h3C, shifting in 8'hA5 -> `tdo` stream = 8'h3C LSB-first; `user_out`=8'hA5 after UpdDR, with `update_pulse` high for exactly 1 `clk`.
- BYPASS (`ir`=F): shift 8'b1011_0010 -> `tdo` equals the input delayed one `tck`, with a leading 0.
- Assert `reset` during ShDR of USER -> state F and `user_out`=0 next cycle; no `tck` edge is detected at reset release while `tck` is held high.

Source files
------------

// File: rtl/jtag_tap.sv
// jtag_tap: IEEE 1149.1-style TAP oversampled in the clk domain.
// tck/tms/tdi are synchronised, tck edges are detected from the synchronised
// copy, and the 16-state TAP FSM plus IR/DR shift logic advance on those edges.
// Optional feature macro: TAP_IDCODE_EN (adds the IDCODE instruction/register).
module jtag_tap #(
   parameter int          IR_WIDTH = 4,
   parameter int          DR_WIDTH = 8,
   parameter logic [31:0] IDCODE   = 32'h10A5_E001
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                tck,
   input  logic                tms,
   input  logic                tdi,
   input  logic [DR_WIDTH-1:0] user_in,
   output logic                tdo,
   output logic                rtck,
   output logic [DR_WIDTH-1:0] user_out,
   output logic [3:0]          tap_state,
   output logic                update_pulse
);

   localparam logic [3:0] TLR    = 4'hF;
   localparam logic [3:0] RTI    = 4'hC;
   localparam logic [3:0] SEL_DR = 4'h7;
   localparam logic [3:0] CAP_DR = 4'h6;
   localparam logic [3:0] SH_DR  = 4'h2;
   localparam logic [3:0] EX1_DR = 4'h1;
   localparam logic [3:0] PAU_DR = 4'h3;
   localparam logic [3:0] EX2_DR = 4'h0;
   localparam logic [3:0] UPD_DR = 4'h5;
   localparam logic [3:0] SEL_IR = 4'h4;
   localparam logic [3:0] CAP_IR = 4'hE;
   localparam logic [3:0] SH_IR  = 4'hA;
   localparam logic [3:0] EX1_IR = 4'h9;
   localparam logic [3:0] PAU_IR = 4'hB;
   localparam logic [3:0] EX2_IR = 4'h8;
   localparam logic [3:0] UPD_IR = 4'hD;

   localparam logic [IR_WIDTH-1:0] IR_IDC     = IR_WIDTH'(1);
   localparam logic [IR_WIDTH-1:0] IR_USER    = IR_WIDTH'(2);
   localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);
`ifdef TAP_IDCODE_EN
   localparam logic [IR_WIDTH-1:0] IR_RESET   = IR_IDC;
`else
   localparam logic [IR_WIDTH-1:0] IR_RESET   = {IR_WIDTH{1'b1}};
`endif

   logic tck_m, tck_s, tck_q;
   logic tms_m, tms_s;
   logic tdi_m, tdi_s;
   logic rise, fall;

   logic [3:0]          state, next_state;
   logic [IR_WIDTH-1:0] ir, ir_sr;
   logic [DR_WIDTH-1:0] user_sr;
   logic                byp_sr;
   logic                sel_user, sel_idc, sel_byp;
   logic                dr_lsb;
`ifdef TAP_IDCODE_EN
   logic [31:0]         id_sr;
`endif

   // Synchronisers run through reset so tck_q matches tck_s at release and no
   // phantom edge is seen.
   always_ff @(posedge clk) begin
      tck_m <= tck;
      tck_s <= tck_m;
      tck_q <= tck_s;
      tms_m <= tms;
      tms_s <= tms_m;
      tdi_m <= tdi;
      tdi_s <= tdi_m;
   end

   assign rise      = tck_s & ~tck_q;
   assign fall      = ~tck_s & tck_q;
   assign rtck      = tck_q;
   assign tap_state = state;

   assign sel_user = (ir == IR_USER);
`ifdef TAP_IDCODE_EN
   assign sel_idc  = (ir == IR_IDC);
`else
   assign sel_idc  = 1'b0;
`endif
   assign sel_byp  = ~sel_user & ~sel_idc;

   // Standard TAP transition diagram.
   always_comb begin
      next_state = state;
      case (state)
         TLR:     next_state = tms_s ? TLR    : RTI;
         RTI:     next_state = tms_s ? SEL_DR : RTI;
         SEL_DR:  next_state = tms_s ? SEL_IR : CAP_DR;
         CAP_DR:  next_state = tms_s ? EX1_DR : SH_DR;
         SH_DR:   next_state = tms_s ? EX1_DR : SH_DR;
         EX1_DR:  next_state = tms_s ? UPD_DR : PAU_DR;
         PAU_DR:  next_state = tms_s ? EX2_DR : PAU_DR;
         EX2_DR:  next_state = tms_s ? UPD_DR : SH_DR;
         UPD_DR:  next_state = tms_s ? SEL_DR : RTI;
         SEL_IR:  next_state = tms_s ? TLR    : CAP_IR;
         CAP_IR:  next_state = tms_s ? EX1_IR : SH_IR;
         SH_IR:   next_state = tms_s ? EX1_IR : SH_IR;
         EX1_IR:  next_state = tms_s ? UPD_IR : PAU_IR;
         PAU_IR:  next_state = tms_s ? EX2_IR : PAU_IR;
         EX2_IR:  next_state = tms_s ? UPD_IR : SH_IR;
         UPD_IR:  next_state = tms_s ? SEL_DR : RTI;
         default: next_state = TLR;
      endcase
   end

   // LSB of whichever data register the current instruction selects.
   always_comb begin
      dr_lsb = byp_sr;
      if (sel_user) dr_lsb = user_sr[0];
`ifdef TAP_IDCODE_EN
      if (sel_idc)  dr_lsb = id_sr[0];
`endif
   end

   // FSM, capture/shift/update on synchronised tck rise; tdo launched on fall.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= TLR;
         ir           <= IR_RESET;
         ir_sr        <= '0;
         user_sr      <= '0;
         byp_sr       <= 1'b0;
         tdo          <= 1'b0;
         user_out     <= '0;
         update_pulse <= 1'b0;
`ifdef TAP_IDCODE_EN
         id_sr        <= '0;
`endif
      end else begin
         update_pulse <= 1'b0;
         if (rise) begin
            state <= next_state;
            case (state)
               CAP_IR: ir_sr <= IR_CAPTURE;
               SH_IR:  ir_sr <= {tdi_s, ir_sr[IR_WIDTH-1:1]};
               UPD_IR: ir    <= ir_sr;
               CAP_DR: begin
                  byp_sr <= 1'b0;
                  if (sel_user) user_sr <= user_in;
`ifdef TAP_IDCODE_EN
                  if (sel_idc)  id_sr   <= IDCODE;
`endif
               end
               SH_DR: begin
                  if (sel_byp)  byp_sr  <= tdi_s;
                  if (sel_user) user_sr <= (user_sr >> 1) | (DR_WIDTH'(tdi_s) << (DR_WIDTH-1));
`ifdef TAP_IDCODE_EN
                  if (sel_idc)  id_sr   <= {tdi_s, id_sr[31:1]};
`endif
               end
               UPD_DR: begin
                  if (sel_user) begin
                     user_out     <= user_sr;
                     update_pulse <= 1'b1;
                  end
               end
               default: ;
            endcase
            // Entering (or staying in) Test-Logic-Reset restores the default instruction.
            if (next_state == TLR) ir <= IR_RESET;
         end else if (fall) begin
            if (state == SH_IR)      tdo <= ir_sr[0];
            else if (state == SH_DR) tdo <= dr_lsb;
            else                     tdo <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_jtag_tap.sv
// Directed self-checking bench for jtag_tap; tck is driven slowly (5 clk high/low).
module tb_jtag_tap;
   logic       clk, reset, tck, tms, tdi;
   logic [7:0] user_in;
   logic       tdo, rtck, update_pulse;
   logic [7:0] user_out;
   logic [3:0] tap_state;

   int checks = 0;
   int errors = 0;
   int pulse_cnt = 0;

`ifdef TAP_IDCODE_EN
   localparam logic [3:0] IR_RST_EXP = 4'h1;
`else
   localparam logic [3:0] IR_RST_EXP = 4'hF;
`endif

   jtag_tap #(.IR_WIDTH(4), .DR_WIDTH(8), .IDCODE(32'h10A5_E001)) dut (
      .clk(clk), .reset(reset), .tck(tck), .tms(tms), .tdi(tdi),
      .user_in(user_in), .tdo(tdo), .rtck(rtck), .user_out(user_out),
      .tap_state(tap_state), .update_pulse(update_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (update_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;

   task automatic tck_cycle(input logic m, input logic d);
      tms = m;
      tdi = d;
      repeat (2) @(negedge clk);
      tck = 1'b1;
      repeat (5) @(negedge clk);
      tck = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic shift_bits(input int n, input logic [31:0] din, output logic [31:0] dout);
      dout = '0;
      for (int i = 0; i < n; i++) begin
         dout[i] = tdo;
         tck_cycle(i == n - 1, din[i]);
      end
   endtask

   // From RTI: scan the DR and return to RTI.
   task automatic dr_scan(input int n, input logic [31:0] din, output logic [31:0] dout);
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b0, 1'b0);
      shift_bits(n, din, dout);
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
   endtask

   // From RTI: scan the IR and return to RTI.
   task automatic ir_scan(input logic [3:0] din, output logic [3:0] dout);
      logic [31:0] tmp;
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b0, 1'b0);
      shift_bits(4, {28'd0, din}, tmp);
      dout = tmp[3:0];
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (4) @(negedge clk);
      checks++; if (tap_state !== 4'hF) begin errors++; $display("FAIL reset_state got %h want F", tap_state); end
      checks++; if (tdo !== 1'b0) begin errors++; $display("FAIL reset_tdo got %b want 0", tdo); end
      checks++; if (user_out !== 8'h00) begin errors++; $display("FAIL reset_user_out got %h want 00", user_out); end
      checks++; if (update_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b want 0", update_pulse); end
      checks++; if (rtck !== 1'b0) begin errors++; $display("FAIL reset_rtck got %b want 0", rtck); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      tck_cycle(1'b0, 1'b0);
      checks++; if (tap_state !== 4'hC) begin errors++; $display("FAIL tlr_to_rti got %h want C", tap_state); end
      for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
      checks++; if (tap_state !== 4'hF) begin errors++; $display("FAIL five_tms_tlr got %h want F", tap_state); end
   endtask

   task automatic test_rtck;
      tms = 1'b1;
      tck = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (rtck !== 1'b0) begin errors++; $display("FAIL rtck_early got %b want 0", rtck); end
      @(negedge clk);
      checks++; if (rtck !== 1'b1) begin errors++; $display("FAIL rtck_lat3 got %b want 1", rtck); end
      repeat (3) @(negedge clk);
      tck = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_idcode;
      logic [31:0] dout;
      tck_cycle(1'b0, 1'b0);
`ifdef TAP_IDCODE_EN
      dr_scan(32, 32'h0, dout);
      checks++; if (dout !== 32'h10A5_E001) begin errors++; $display("FAIL idcode_read got %h want 10a5e001", dout); end
`else
      dr_scan(8, 32'h0000_00B2, dout);
      checks++; if (dout[7:0] !== 8'h64) begin errors++; $display("FAIL reset_bypass got %h want 64", dout[7:0]); end
`endif
   endtask

   task automatic test_ir_scan;
      logic [3:0] dout;
      ir_scan(4'h2, dout);
      checks++; if (dout !== 4'b0001) begin errors++; $display("FAIL ir_capture got %b want 0001", dout); end
      checks++; if (dut.ir !== 4'h2) begin errors++; $display("FAIL ir_update got %h want 2", dut.ir); end
   endtask

   task automatic test_user_dr;
      logic [31:0] dout;
      int c0;
      user_in = 8'h3C;
      c0 = pulse_cnt;
      dr_scan(8, 32'h0000_00A5, dout);
      checks++; if (dout[7:0] !== 8'h3C) begin errors++; $display("FAIL user_capture got %h want 3c", dout[7:0]); end
      checks++; if (user_out !== 8'hA5) begin errors++; $display("FAIL user_update got %h want a5", user_out); end
      checks++; if (pulse_cnt - c0 !== 1) begin errors++; $display("FAIL update_pulse_len got %0d want 1", pulse_cnt - c0); end
      checks++; if (tap_state !== 4'hC) begin errors++; $display("FAIL user_end_state got %h want C", tap_state); end
   endtask

   task automatic test_bypass;
      logic [3:0]  iout;
      logic [31:0] dout;
      int c0;
      ir_scan(4'hF, iout);
      c0 = pulse_cnt;
      dr_scan(8, 32'h0000_00B2, dout);
      checks++; if (dout[7:0] !== 8'h64) begin errors++; $display("FAIL bypass_f got %h want 64", dout[7:0]); end
      checks++; if (user_out !== 8'hA5) begin errors++; $display("FAIL bypass_user_hold got %h want a5", user_out); end
      checks++; if (pulse_cnt != c0) begin errors++; $display("FAIL bypass_no_pulse got %0d want 0", pulse_cnt - c0); end
      ir_scan(4'h3, iout);
      dr_scan(8, 32'h0000_005A, dout);
      checks++; if (dout[7:0] !== 8'hB4) begin errors++; $display("FAIL bypass_other got %h want b4", dout[7:0]); end
   endtask

   task automatic test_tlr_ir;
      logic [3:0] iout;
      ir_scan(4'h2, iout);
      for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
      checks++; if (dut.ir !== IR_RST_EXP) begin errors++; $display("FAIL tlr_ir got %h want %h", dut.ir, IR_RST_EXP); end
      checks++; if (user_out !== 8'hA5) begin errors++; $display("FAIL tlr_user_keep got %h want a5", user_out); end
      tck_cycle(1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_shift;
      logic [3:0] iout;
      ir_scan(4'h2, iout);
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b0, 1'b1);
      checks++; if (tap_state !== 4'h2) begin errors++; $display("FAIL mid_shdr got %h want 2", tap_state); end
      tms = 1'b0;
      tck = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++; if (tap_state !== 4'hF) begin errors++; $display("FAIL mid_reset_state got %h want F", tap_state); end
      checks++; if (user_out !== 8'h00) begin errors++; $display("FAIL mid_reset_user got %h want 00", user_out); end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      checks++; if (tap_state !== 4'hF) begin errors++; $display("FAIL release_no_edge got %h want F", tap_state); end
      checks++; if (tdo !== 1'b0) begin errors++; $display("FAIL release_tdo got %b want 0", tdo); end
      tck = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; tck = 1'b0; tms = 1'b1; tdi = 1'b0; user_in = 8'h00;
      test_reset();
      test_rtck();
      test_idcode();
      test_ir_scan();
      test_user_dr();
      test_bypass();
      test_tlr_ir();
      test_reset_mid_shift();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
